// File: rtl/mult_arbiter.sv
// Round-robin sharing of one combinational multiplier among NumReq valid/ready requesters.
// Product returned two cycles after acceptance; new grants wait until the response handshake completes.
module mult_arbiter #(
  parameter  int Width  = 8,
  parameter  int NumReq = 4,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq*Width-1:0]   req_a_i,
  input  logic [NumReq*Width-1:0]   req_b_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic [Width-1:0]          mul_a_o,
  output logic [Width-1:0]          mul_b_o,
  input  logic [2*Width-1:0]        mul_prod_i,
  output logic [NumReq-1:0]         rsp_valid_o,
  output logic [2*Width-1:0]        rsp_prod_o,
  input  logic [NumReq-1:0]         rsp_ready_i,
  output logic                      busy_o,
  output logic [IdxW-1:0]           grant_idx_o
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t             state_q, state_d;
  logic [IdxW-1:0]    ptr_q, gidx_q, pick, cand;
  logic               found;
  logic [Width-1:0]   op_a_q, op_b_q;
  logic [2*Width-1:0] res_q;

  // Search starts just after the last grant, so the last winner is tried last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NumReq; i++) begin
      cand = IdxW'((int'(ptr_q) + i) % NumReq);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready_i[gidx_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a_q <= '0;
      op_b_q <= '0;
      res_q  <= '0;
      gidx_q <= '0;
      ptr_q  <= IdxW'(NumReq - 1);
    end else begin
      if (state_q == IDLE && found) begin
        op_a_q <= req_a_i[pick*Width +: Width];
        op_b_q <= req_b_i[pick*Width +: Width];
        gidx_q <= pick;
        ptr_q  <= pick;
      end
      if (state_q == CALC) begin
        res_q <= mul_prod_i;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (rst_ni && state_q == IDLE && found) req_ready_o[pick] = 1'b1;
    if (state_q == RESP) rsp_valid_o[gidx_q] = 1'b1;
  end

  assign mul_a_o     = op_a_q;
  assign mul_b_o     = op_b_q;
  assign rsp_prod_o  = res_q;
  assign busy_o      = (state_q != IDLE);
  assign grant_idx_o = gidx_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: queued requester drivers, a transaction-level reference model
// compared every cycle, and directed literal checks on grant order and products.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [3:0]  req_ready;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_prod;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_prod;
  logic [3:0]  rsp_rdy;
  logic        busy;
  logic [1:0]  gidx;

  int n_chk = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // The shared multiplier itself
  assign mul_prod = {8'd0, mul_a} * {8'd0, mul_b};

  mult_arbiter #(.Width(8), .NumReq(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_prod_i(mul_prod),
    .rsp_valid_o(rsp_valid), .rsp_prod_o(rsp_prod), .rsp_ready_i(rsp_rdy),
    .busy_o(busy), .grant_idx_o(gidx)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester job queues
  logic [7:0] ja[4][16], jb[4][16];
  int wr[4] = '{0, 0, 0, 0};
  int rd[4] = '{0, 0, 0, 0};
  logic [3:0] popm = '0;

  task automatic push(input int k, input int a, input int b);
    ja[k][wr[k] % 16] = 8'(a);
    jb[k][wr[k] % 16] = 8'(b);
    wr[k]++;
  endtask

  always @(negedge clk) popm = req_valid & req_ready & {4{rst_n}};

  always begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (popm[k]) rd[k]++;
    popm = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      req_valid[k]      = (rd[k] != wr[k]);
      req_a[k*8 +: 8]   = ja[k][rd[k] % 16];
      req_b[k*8 +: 8]   = jb[k][rd[k] % 16];
    end
  end

  // Reference model: transaction phase, last winner, latched operands, result
  int         m_phase, m_last, m_g;
  logic [7:0] m_a, m_b;
  logic [15:0] m_res;
  int gl[$], gcyc[$], rl_idx[$], rl_prod[$];

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int d = 1; d <= 4; d++) if (v[(last + d) % 4]) return (last + d) % 4;
    return -1;
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    int p;
    if (!rst_n) begin
      m_phase = 0; m_last = 3; m_g = 0; m_a = 0; m_b = 0; m_res = 0;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mul_a", 32'(mul_a), 0);
      chk("rst_mul_b", 32'(mul_b), 0);
      chk("rst_rsp_prod", 32'(rsp_prod), 0);
      chk("rst_grant_idx", 32'(gidx), 0);
    end else begin
      p = (m_phase == 0) ? rr_pick(req_valid, m_last) : -1;
      chk("req_ready", 32'(req_ready), (p >= 0) ? (32'd1 << p) : 0);
      chk("rsp_valid", 32'(rsp_valid), (m_phase == 2) ? (32'd1 << m_g) : 0);
      chk("rsp_prod", 32'(rsp_prod), 32'(m_res));
      chk("mul_a", 32'(mul_a), 32'(m_a));
      chk("mul_b", 32'(mul_b), 32'(m_b));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("grant_idx", 32'(gidx), 32'(m_g));
      if (req_ready != 0) begin gl.push_back(oh2i(req_ready)); gcyc.push_back(cyc); end
      if ((rsp_valid & rsp_rdy) != 0) begin
        rl_idx.push_back(oh2i(rsp_valid));
        rl_prod.push_back(int'(rsp_prod));
      end
      case (m_phase)
        0: if (p >= 0) begin
             m_phase = 1; m_a = req_a[p*8 +: 8]; m_b = req_b[p*8 +: 8]; m_g = p; m_last = p;
           end
        1: begin m_res = 16'(m_a) * 16'(m_b); m_phase = 2; end
        default: if (rsp_rdy[m_g]) m_phase = 0;
      endcase
    end
  end

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk);
      #3;
      done = (rd[0] == wr[0]) && (rd[1] == wr[1]) && (rd[2] == wr[2]) && (rd[3] == wr[3])
             && !busy && (req_valid == 0);
    end
    if (!done) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int bc, n0;
    bit seen;
    int exp_p[8];
    rst_n = 1'b0;
    rsp_rdy = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request on requester 0
    push(0, 12, 13);
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'b0001);
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bc += int'(busy);
      if (i == 1) begin
        chk("t1_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("t1_prod", 32'(rsp_prod), 156);
      end
    end
    chk("t1_busy_cycles", bc, 2);
    wait_idle();

    // Full-width product, zero operand
    n0 = rl_prod.size();
    push(2, 255, 255);
    push(2, 0, 200);
    wait_idle();
    chk("t2_count", rl_prod.size() - n0, 2);
    chk("t2_prod_max", rl_prod[n0], 65025);
    chk("t2_idx", rl_idx[n0], 2);
    chk("t2_prod_zero", rl_prod[n0+1], 0);

    // Fairness from reset with all requesters busy
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    gl.delete(); gcyc.delete();
    n0 = rl_prod.size();
    for (int k = 0; k < 4; k++) push(k, 10 + k, 3 + k);
    for (int k = 0; k < 4; k++) push(k, 20 + k, 5);
    exp_p = '{30, 44, 60, 78, 100, 105, 110, 115};
    wait_idle();
    chk("t3_grants", gl.size(), 8);
    for (int i = 0; i < 6; i++) chk("t3_order", gl[i], i % 4);
    for (int i = 1; i < 6; i++) chk("t3_interval", gcyc[i] - gcyc[i-1], 3);
    for (int i = 0; i < 8; i++) begin
      chk("t3_rsp_idx", rl_idx[n0+i], i % 4);
      chk("t3_rsp_prod", rl_prod[n0+i], exp_p[i]);
    end

    // Wrap-around after serving requester 1
    gl.delete();
    push(1, 2, 3);
    wait_idle();
    chk("t4_first", gl[0], 1);
    gl.delete();
    n0 = rl_prod.size();
    push(1, 4, 5);
    push(3, 6, 7);
    wait_idle();
    chk("t4_wrap0", gl[0], 3);
    chk("t4_wrap1", gl[1], 1);
    chk("t4_prod0", rl_prod[n0], 42);
    chk("t4_prod1", rl_prod[n0+1], 20);

    // Response backpressure with a competing request
    rsp_rdy = 4'b1011;
    push(2, 7, 9);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid[2];
    end
    if (!seen) chk("t5_rsp_timeout", 1, 0);
    push(0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", 32'(rsp_valid), 32'b0100);
      chk("t5_hold_prod", 32'(rsp_prod), 63);
      chk("t5_no_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_rdy = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("t5_next_grant", 32'(req_ready), 32'b0001);
    wait_idle();

    // Reset during CALC discards the transaction
    push(3, 5, 5);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = req_ready[3];
    end
    if (!seen) chk("t6_grant_timeout", 1, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_rst_mul_a", 32'(mul_a), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    n0 = rl_prod.size();
    push(0, 2, 2);
    push(3, 3, 3);
    @(negedge clk);
    chk("t6_grant0", 32'(req_ready), 32'b0001);
    wait_idle();
    chk("t6_rsp_count", rl_prod.size() - n0, 2);
    chk("t6_rsp0_idx", rl_idx[n0], 0);
    chk("t6_rsp0_prod", rl_prod[n0], 4);
    chk("t6_rsp1_idx", rl_idx[n0+1], 3);
    chk("t6_rsp1_prod", rl_prod[n0+1], 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
